// File: rtl/dispatch_scheduler_pkg.sv
// Shared types and the round-robin selection helper for the dispatch scheduler.
package dispatch_pkg;

    localparam int unsigned NT  = 4;
    localparam int unsigned IDW = 6;
    localparam int unsigned PW  = $clog2(NT);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_e;

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] idx;
    } pick_t;

    // First eligible index at or after ptr, wrapping mod NT (NT is a power of two).
    function automatic pick_t rr_pick(input logic [NT-1:0] eligible, input logic [PW-1:0] ptr);
        pick_t         res;
        logic [PW-1:0] cand;
        res = '0;
        for (int unsigned k = 0; k < NT; k++) begin
            cand = ptr + PW'(k);
            if (!res.valid && eligible[cand]) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dispatch_scheduler_if.sv
// AXI-stream style packet channel shared by the upstream and downstream sides.
interface dispatch_scheduler_if #(parameter int unsigned BW = 32);

    localparam int unsigned BWB = BW / 8;

    logic           TVALID;
    logic           TREADY;
    logic [BW-1:0]  TDATA;
    logic [BWB-1:0] TKEEP;
    logic           TLAST;

    modport master (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TKEEP, TLAST, output TREADY);

endinterface

// File: rtl/dispatch_scheduler_credit_counter.sv
// Per-tile outstanding-packet credit counter with a sticky overflow flag.
module credit_counter #(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CW      = $clog2(MAX_OUT + 1)
) (
    input  logic          clk_line,
    input  logic          clk_line_rst_high,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          ovf_o
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    // Simultaneous return and consume cancel out.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (inc_i && !dec_i) begin
            if (count_q == MAX_C) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            count_q <= MAX_C;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/dispatch_scheduler.sv
// Packet scheduler: round-robin tile pick per packet, destination rewrite on the
// first beat, atomic pass-through of the rest, credit-limited per tile.
module dispatch_scheduler
    import dispatch_pkg::*;
#(
    parameter int unsigned          BW       = 32,
    parameter int unsigned          BWB      = BW / 8,
    parameter int unsigned          DEST_LSB = 0,
    parameter logic [IDW*NT-1:0]    TILE_IDS = {6'd4, 6'd3, 6'd2, 6'd1},
    parameter int unsigned          MAX_OUT  = 4,
    parameter int unsigned          CW       = $clog2(MAX_OUT + 1)
) (
    input  logic                  clk_line,
    input  logic                  clk_line_rst_high,
    dispatch_scheduler_if.slave   s,
    dispatch_scheduler_if.master  m,
    input  logic [NT-1:0]         tile_enable,
    input  logic [NT-1:0]         tile_done,
    output logic [NT*CW-1:0]      credits,
    output logic                  busy,
    output logic                  err_credit_ovf
);

    state_e        state_q, state_d;
    logic [PW-1:0] sel_q, sel_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;

    logic [CW-1:0]  cnt [NT];
    logic [NT-1:0]  ovf;
    logic [NT-1:0]  eligible;
    logic [NT-1:0]  dec_c;
    pick_t          pick;
    logic [IDW-1:0] tile_id;
    logic [BW-1:0]  hdr_data;
    logic [BWB-1:0] keep_c;

    for (genvar g = 0; g < NT; g++) begin : g_credit
        credit_counter #(.MAX_OUT(MAX_OUT), .CW(CW)) u_credit (
            .clk_line          (clk_line),
            .clk_line_rst_high (clk_line_rst_high),
            .inc_i             (tile_done[g]),
            .dec_i             (dec_c[g]),
            .count_o           (cnt[g]),
            .ovf_o             (ovf[g])
        );
        assign credits[g*CW +: CW] = cnt[g];
        assign eligible[g]         = tile_enable[g] && (cnt[g] != '0);
    end

    assign pick           = rr_pick(eligible, rr_ptr_q);
    assign tile_id        = TILE_IDS[32'(sel_q)*IDW +: IDW];
    assign keep_c         = s.TKEEP;
    assign busy           = (state_q != IDLE);
    assign err_credit_ovf = |ovf;

    // First beat carries the selected tile's ID in its destination field.
    always_comb begin
        hdr_data                     = s.TDATA;
        hdr_data[DEST_LSB +: IDW]    = tile_id;
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        dec_c    = '0;
        s.TREADY = 1'b0;
        m.TVALID = 1'b0;
        m.TDATA  = s.TDATA;
        m.TKEEP  = keep_c;
        m.TLAST  = s.TLAST;
        case (state_q)
            IDLE: begin
                if (s.TVALID && pick.valid) begin
                    sel_d   = pick.idx;
                    state_d = HDR;
                end
            end
            HDR: begin
                m.TVALID = s.TVALID;
                s.TREADY = m.TREADY;
                m.TDATA  = hdr_data;
                if (s.TVALID && m.TREADY) begin
                    dec_c[sel_q] = 1'b1;
                    rr_ptr_d     = sel_q + PW'(1);
                    state_d      = s.TLAST ? IDLE : BODY;
                end
            end
            BODY: begin
                m.TVALID = s.TVALID;
                s.TREADY = m.TREADY;
                if (s.TVALID && m.TREADY && s.TLAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: round-robin order, header rewrite,
// masking, credit exhaustion/return, overflow flag and mid-packet reset.
module tb_dispatch_scheduler;
    import dispatch_pkg::*;

    localparam int unsigned BW  = 32;
    localparam int unsigned CW  = 3;

    logic               clk_line = 1'b0;
    logic               clk_line_rst_high;
    logic [NT-1:0]      tile_enable;
    logic [NT-1:0]      tile_done;
    logic [NT*CW-1:0]   credits;
    logic               busy;
    logic               err_credit_ovf;

    int checks = 0;
    int errors = 0;
    int w0;

    dispatch_scheduler_if #(.BW(BW)) s_if ();
    dispatch_scheduler_if #(.BW(BW)) m_if ();

    dispatch_scheduler dut (
        .clk_line          (clk_line),
        .clk_line_rst_high (clk_line_rst_high),
        .s                 (s_if),
        .m                 (m_if),
        .tile_enable       (tile_enable),
        .tile_done         (tile_done),
        .credits           (credits),
        .busy              (busy),
        .err_credit_ovf    (err_credit_ovf)
    );

    always #5 clk_line = ~clk_line;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_line);
        clk_line_rst_high = 1'b1;
        s_if.TVALID = 1'b0;
        s_if.TLAST  = 1'b0;
        m_if.TREADY = 1'b0;
        tile_done   = '0;
        @(negedge clk_line);
        @(negedge clk_line);
        clk_line_rst_high = 1'b0;
    endtask

    // Drives one packet; the bench models IDLE->HDR timing (one bubble) itself.
    task automatic send_pkt(input int nb, input logic [31:0] d0, input logic [5:0] dest,
                            input bit tog, input logic [3:0] done_hdr, output int wait0);
        int          cyc;
        bit          ok;
        logic        exp_rdy;
        logic [31:0] d;
        logic [31:0] exp_d;
        logic [3:0]  k;
        cyc   = 0;
        wait0 = -1;
        for (int i = 0; i < nb; i++) begin
            d = d0 + 32'(i) * 32'h0010_1010;
            k = (i == nb - 1) ? 4'h7 : 4'hF;
            s_if.TVALID = 1'b1;
            s_if.TDATA  = d;
            s_if.TKEEP  = k;
            s_if.TLAST  = (i == nb - 1);
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                m_if.TREADY = tog ? ~cyc[0] : 1'b1;
                #1;
                exp_rdy = (i > 0 || c > 0) && m_if.TREADY;
                check("m_tvalid", m_if.TVALID, (i > 0 || c > 0));
                check("s_tready", s_if.TREADY, exp_rdy);
                if (exp_rdy) begin
                    ok = 1'b1;
                    if (i == 0) wait0 = c;
                    exp_d = (i == 0) ? {d[31:6], dest} : d;
                    check("m_tdata", m_if.TDATA, exp_d);
                    check("m_tkeep", m_if.TKEEP, k);
                    check("m_tlast", m_if.TLAST, (i == nb - 1));
                    tile_done = (i == 0) ? done_hdr : 4'b0000;
                end
                @(posedge clk_line);
                @(negedge clk_line);
                tile_done = '0;
                cyc++;
            end
            if (!ok) check("beat_timeout", 64'd0, 64'd1);
        end
        s_if.TVALID = 1'b0;
        s_if.TLAST  = 1'b0;
    endtask

    initial begin
        clk_line_rst_high = 1'b1;
        tile_enable = 4'hF;
        tile_done   = '0;
        s_if.TVALID = 1'b0;
        s_if.TDATA  = '0;
        s_if.TKEEP  = '0;
        s_if.TLAST  = 1'b0;
        m_if.TREADY = 1'b0;
        do_reset();

        // Reset state
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_m_tvalid", m_if.TVALID, 1'b0);
        check("rst_s_tready", s_if.TREADY, 1'b0);
        check("rst_credits", credits, 12'h924);
        check("rst_err", err_credit_ovf, 1'b0);
        @(negedge clk_line);

        // 1: four single-beat packets, all tiles, one bubble each
        send_pkt(1, 32'hA5A5_5AC0, 6'd1, 1'b0, 4'h0, w0); check("t1_bubble0", 64'(w0), 64'd1);
        send_pkt(1, 32'h1234_5678, 6'd2, 1'b0, 4'h0, w0); check("t1_bubble1", 64'(w0), 64'd1);
        send_pkt(1, 32'hFFFF_FFFF, 6'd3, 1'b0, 4'h0, w0); check("t1_bubble2", 64'(w0), 64'd1);
        send_pkt(1, 32'h0000_0000, 6'd4, 1'b0, 4'h0, w0); check("t1_bubble3", 64'(w0), 64'd1);
        check("t1_credits", credits, 12'h6DB);

        // 2: three-beat packet with toggling downstream ready
        send_pkt(3, 32'hDEAD_BEEF, 6'd1, 1'b1, 4'h0, w0);
        #1;
        check("t2_idle", busy, 1'b0);
        check("t2_credits", credits, 12'h6DA);
        @(negedge clk_line);

        // 3: tiles 0 and 2 only, from a fresh reset
        do_reset();
        tile_enable = 4'b0101;
        send_pkt(1, 32'h1111_1111, 6'd1, 1'b0, 4'h0, w0);
        send_pkt(1, 32'h2222_2222, 6'd3, 1'b0, 4'h0, w0);
        send_pkt(1, 32'h3333_3333, 6'd1, 1'b0, 4'h0, w0);
        send_pkt(1, 32'h4444_4444, 6'd3, 1'b0, 4'h0, w0);
        check("t3_credits", credits, 12'h8A2);

        // 4: exhaust tile 0, packet blocked until a credit returns
        tile_enable = 4'b0001;
        send_pkt(1, 32'h5555_5555, 6'd1, 1'b0, 4'h0, w0);
        send_pkt(1, 32'h6666_6666, 6'd1, 1'b0, 4'h0, w0);
        check("t4_drained", credits, 12'h8A0);
        s_if.TVALID = 1'b1;
        s_if.TDATA  = 32'h7777_7777;
        s_if.TLAST  = 1'b1;
        m_if.TREADY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t4_blocked_rdy", s_if.TREADY, 1'b0);
            check("t4_blocked_busy", busy, 1'b0);
            @(negedge clk_line);
        end
        tile_done = 4'b0001;
        @(negedge clk_line);
        tile_done = '0;
        check("t4_returned", credits, 12'h8A1);
        send_pkt(1, 32'h7777_7777, 6'd1, 1'b0, 4'h0, w0);
        check("t4_bubble", 64'(w0), 64'd1);
        check("t4_credits", credits, 12'h8A0);

        // 5: simultaneous consume/return, then overflow on a full tile
        tile_enable = 4'b0100;
        send_pkt(1, 32'h8888_8888, 6'd3, 1'b0, 4'b0100, w0);
        check("t5_same_cycle", credits, 12'h8A0);
        check("t5_no_err", err_credit_ovf, 1'b0);
        tile_done = 4'b1000;
        @(negedge clk_line);
        tile_done = '0;
        check("t5_ovf_credits", credits, 12'h8A0);
        check("t5_ovf_err", err_credit_ovf, 1'b1);
        send_pkt(1, 32'h9999_9999, 6'd3, 1'b0, 4'h0, w0);
        check("t5_credits2", credits, 12'h860);
        check("t5_sticky", err_credit_ovf, 1'b1);

        // 6: reset in the middle of a packet body
        tile_enable = 4'hF;
        s_if.TVALID = 1'b1;
        s_if.TDATA  = 32'hCAFE_0000;
        s_if.TKEEP  = 4'hF;
        s_if.TLAST  = 1'b0;
        m_if.TREADY = 1'b1;
        @(negedge clk_line);
        #1;
        check("t6_hdr_busy", busy, 1'b1);
        @(negedge clk_line);
        s_if.TDATA = 32'hCAFE_0001;
        #1;
        check("t6_body_valid", m_if.TVALID, 1'b1);
        clk_line_rst_high = 1'b1;
        #1;
        check("t6_rst_valid", m_if.TVALID, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_credits", credits, 12'h924);
        check("t6_rst_err", err_credit_ovf, 1'b0);
        @(negedge clk_line);
        clk_line_rst_high = 1'b0;
        s_if.TVALID = 1'b0;
        send_pkt(1, 32'hBEEF_F00D, 6'd1, 1'b0, 4'h0, w0);
        check("t6_bubble", 64'(w0), 64'd1);
        check("t6_credits", credits, 12'h923);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
